// File: rtl/counter_step_driver_if.sv
`default_nettype none
// ============================================================================
// Module   : counter_step_driver_if
// Brief    : Step-request / counter-drive bundle for counter_step_driver.
// Revision : 1.0
// ============================================================================
interface counter_step_driver_if #(
    parameter int PEND_W = 4
);
    logic                     up_req_i;
    logic                     dn_req_i;
    logic                     clr_req_i;
    logic                     inc_o;
    logic                     dec_o;
    logic                     clr_o;
    logic signed [PEND_W-1:0] pend_o;
    logic                     busy_o;
    logic                     drop_o;

    modport slave (
        input  up_req_i, dn_req_i, clr_req_i,
        output inc_o, dec_o, clr_o, pend_o, busy_o, drop_o
    );

    modport master (
        output up_req_i, dn_req_i, clr_req_i,
        input  inc_o, dec_o, clr_o, pend_o, busy_o, drop_o
    );
endinterface
`default_nettype wire

// File: rtl/counter_step_driver.sv
`default_nettype none
// ============================================================================
// Module   : counter_step_driver
// Brief    : Paces queued up/down/clear strobes into INC/DEC/CLR edge pulses.
// Revision : 1.0
// ============================================================================
module counter_step_driver #(
    parameter int LOW_CYC = 2,
    parameter int GAP_CYC = 2,
    parameter int CLR_CYC = 1,
    parameter int PEND_W  = 4
) (
    input  wire logic            clk_i,
    input  wire logic            rst_i,
    counter_step_driver_if.slave bus
);
    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LOW_UP = 3'd1,
        S_LOW_DN = 3'd2,
        S_GAP    = 3'd3,
        S_CLEAR  = 3'd4
    } state_t;

    localparam int C_MAX1 = (LOW_CYC > GAP_CYC) ? LOW_CYC : GAP_CYC;
    localparam int C_CMAX = (C_MAX1 > CLR_CYC) ? C_MAX1 : CLR_CYC;
    localparam int CNT_W  = (C_CMAX > 1) ? $clog2(C_CMAX) : 1;
    localparam logic [CNT_W-1:0] C_LOW_LAST = CNT_W'(LOW_CYC - 1);
    localparam logic [CNT_W-1:0] C_GAP_LAST = CNT_W'(GAP_CYC - 1);
    localparam logic [CNT_W-1:0] C_CLR_LAST = CNT_W'(CLR_CYC - 1);
    localparam int C_PMAX = (1 <<< (PEND_W - 1)) - 1;
    localparam int C_PMIN = -(1 <<< (PEND_W - 1));

    state_t                   state_q, state_d;
    logic [CNT_W-1:0]         cnt_q, cnt_d;
    logic                     inc_q, inc_d;
    logic                     dec_q, dec_d;
    logic                     clr_q, clr_d;
    logic                     drop_q, drop_d;
    logic signed [PEND_W-1:0] pend_q, pend_d;

    int   w_cons;
    int   w_base;
    int   w_trial;
    logic w_accept;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            inc_q   <= 1'b1;
            dec_q   <= 1'b1;
            clr_q   <= 1'b0;
            drop_q  <= 1'b0;
            pend_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            inc_q   <= inc_d;
            dec_q   <= dec_d;
            clr_q   <= clr_d;
            drop_q  <= drop_d;
            pend_q  <= pend_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        inc_d    = inc_q;
        dec_d    = dec_q;
        clr_d    = clr_q;
        drop_d   = 1'b0;
        pend_d   = pend_q;
        w_cons   = 0;
        w_accept = 1'b1;
        w_base   = 0;
        w_trial  = 0;

        case (state_q)
            S_IDLE: begin
                if (!pend_q[PEND_W-1] && (pend_q != '0)) begin
                    state_d = S_LOW_UP;
                    inc_d   = 1'b0;
                    cnt_d   = '0;
                    w_cons  = 1;
                end else if (pend_q[PEND_W-1]) begin
                    state_d = S_LOW_DN;
                    dec_d   = 1'b0;
                    cnt_d   = '0;
                    w_cons  = -1;
                end
            end
            S_LOW_UP, S_LOW_DN: begin
                if (cnt_q == C_LOW_LAST) begin
                    state_d = S_GAP;
                    inc_d   = 1'b1;
                    dec_d   = 1'b1;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_GAP: begin
                if (cnt_q == C_GAP_LAST) begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_CLEAR: begin
                w_accept = 1'b0;
                if (cnt_q == C_CLR_LAST) begin
                    state_d = S_GAP;
                    clr_d   = 1'b0;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = S_IDLE;
                inc_d   = 1'b1;
                dec_d   = 1'b1;
                clr_d   = 1'b0;
                cnt_d   = '0;
            end
        endcase

        // Consumption never leaves range; only a new request can overflow it.
        w_base = int'(pend_q) - w_cons;
        pend_d = w_base[PEND_W-1:0];
        if (w_accept) begin
            w_trial = w_base + int'(bus.up_req_i) - int'(bus.dn_req_i);
            if ((w_trial > C_PMAX) || (w_trial < C_PMIN)) begin
                drop_d = 1'b1;
            end else begin
                pend_d = w_trial[PEND_W-1:0];
            end
        end

        // Clear overrides everything, including a pulse in progress.
        if (bus.clr_req_i) begin
            state_d = S_CLEAR;
            cnt_d   = '0;
            clr_d   = 1'b1;
            inc_d   = 1'b1;
            dec_d   = 1'b1;
            pend_d  = '0;
            drop_d  = 1'b0;
        end
    end

    assign bus.inc_o  = inc_q;
    assign bus.dec_o  = dec_q;
    assign bus.clr_o  = clr_q;
    assign bus.drop_o = drop_q;
    assign bus.pend_o = pend_q;
    assign bus.busy_o = (state_q != S_IDLE) || (pend_q != '0);
endmodule
`default_nettype wire

// File: tb/tb_counter_step_driver.sv
`default_nettype none
// ============================================================================
// Module   : tb_counter_step_driver
// Brief    : Directed self-checking bench for counter_step_driver.
// Revision : 1.0
// ============================================================================
`timescale 1ns/1ps
module tb_counter_step_driver;
    logic clk;
    logic rst;
    int   tests_run;
    int   fails;
    int   cyc;
    int   inc_falls;
    int   dec_falls;
    int   both_low;
    int   fall_cyc [0:255];
    logic prev_inc;
    logic prev_dec;

    counter_step_driver_if #(.PEND_W(4)) bus ();

    counter_step_driver #(
        .LOW_CYC (2),
        .GAP_CYC (2),
        .CLR_CYC (1),
        .PEND_W  (4)
    ) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc = cyc + 1;

    initial begin
        inc_falls = 0;
        dec_falls = 0;
        both_low  = 0;
        prev_inc  = 1'b1;
        prev_dec  = 1'b1;
    end

    always @(negedge clk) begin
        if (prev_inc && !bus.inc_o) begin
            if (inc_falls < 256) fall_cyc[inc_falls] = cyc;
            inc_falls = inc_falls + 1;
        end
        if (prev_dec && !bus.dec_o) dec_falls = dec_falls + 1;
        if (!bus.inc_o && !bus.dec_o) both_low = both_low + 1;
        prev_inc = bus.inc_o;
        prev_dec = bus.dec_o;
    end

    task automatic chk(input string tag, input int got, input int exp);
        tests_run = tests_run + 1;
        if (got !== exp) begin
            fails = fails + 1;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle(input string tag, input int budget);
        int n;
        n = 0;
        while (bus.busy_o && n < budget) begin
            tick();
            n = n + 1;
        end
        chk(tag, int'(bus.busy_o), 0);
    endtask

    initial begin
        int bad;
        int base_i;
        int base_d;
        int peak;
        int drops;
        int drop_at;

        tests_run = 0;
        fails     = 0;
        rst       = 1'b1;
        bus.up_req_i  = 1'b0;
        bus.dn_req_i  = 1'b0;
        bus.clr_req_i = 1'b0;

        // 1: reset values, then quiet idle
        repeat (3) tick();
        chk("rst_inc",  int'(bus.inc_o),  1);
        chk("rst_dec",  int'(bus.dec_o),  1);
        chk("rst_clr",  int'(bus.clr_o),  0);
        chk("rst_pend", int'(bus.pend_o), 0);
        chk("rst_busy", int'(bus.busy_o), 0);
        chk("rst_drop", int'(bus.drop_o), 0);
        rst = 1'b0;
        bad = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (!bus.inc_o || !bus.dec_o || bus.clr_o || bus.busy_o || bus.pend_o != 0) bad++;
        end
        chk("idle_hold", bad, 0);

        // 2: single up step timeline
        base_i = inc_falls;
        bus.up_req_i = 1'b1; tick(); bus.up_req_i = 1'b0;
        chk("t2_e1_pend", int'(bus.pend_o), 1);
        chk("t2_e1_inc",  int'(bus.inc_o),  1);
        tick();
        chk("t2_e2_inc",  int'(bus.inc_o),  0);
        chk("t2_e2_pend", int'(bus.pend_o), 0);
        tick();
        chk("t2_e3_inc",  int'(bus.inc_o),  0);
        tick();
        chk("t2_e4_inc",  int'(bus.inc_o),  1);
        chk("t2_e4_busy", int'(bus.busy_o), 1);
        tick();
        chk("t2_e5_busy", int'(bus.busy_o), 1);
        tick();
        chk("t2_e6_busy", int'(bus.busy_o), 0);
        chk("t2_pulses",  inc_falls - base_i, 1);

        // 3: ten back-to-back ups saturate the queue
        base_i  = inc_falls;
        peak    = 0;
        drops   = 0;
        drop_at = 0;
        for (int i = 1; i <= 10; i++) begin
            bus.up_req_i = 1'b1;
            tick();
            if (bus.drop_o) begin
                drops++;
                drop_at = i;
            end
            if (int'(bus.pend_o) > peak) peak = int'(bus.pend_o);
        end
        bus.up_req_i = 1'b0;
        tick();
        if (bus.drop_o) drops++;
        chk("t3_peak",    peak,    7);
        chk("t3_drops",   drops,   1);
        chk("t3_drop_at", drop_at, 10);
        wait_idle("t3_idle", 100);
        chk("t3_pulses", inc_falls - base_i, 9);
        bad = 0;
        for (int k = 1; k < 9; k++) begin
            if (fall_cyc[base_i + k] - fall_cyc[base_i + k - 1] != 5) bad++;
        end
        chk("t3_spacing", bad, 0);

        // 4: cancelling requests, then two downs
        base_i = inc_falls;
        base_d = dec_falls;
        bus.up_req_i = 1'b1; bus.dn_req_i = 1'b1; tick();
        bus.up_req_i = 1'b0; bus.dn_req_i = 1'b0;
        chk("t4_cancel_pend", int'(bus.pend_o), 0);
        chk("t4_cancel_drop", int'(bus.drop_o), 0);
        repeat (5) tick();
        chk("t4_cancel_pulse", (inc_falls - base_i) + (dec_falls - base_d), 0);
        bus.dn_req_i = 1'b1; tick();
        chk("t4_dn_pend", int'(bus.pend_o), -1);
        tick(); bus.dn_req_i = 1'b0;
        chk("t4_dec_low", int'(bus.dec_o), 0);
        wait_idle("t4_idle", 100);
        chk("t4_dec_pulses", dec_falls - base_d, 2);
        chk("t4_inc_pulses", inc_falls - base_i, 0);
        chk("t4_pend", int'(bus.pend_o), 0);

        // 5: clear during LOW_UP with a queued step
        bus.up_req_i = 1'b1; tick(); tick(); bus.up_req_i = 1'b0; tick();
        chk("t5_inc_low", int'(bus.inc_o),  0);
        chk("t5_pend_q",  int'(bus.pend_o), 1);
        bus.clr_req_i = 1'b1; tick(); bus.clr_req_i = 1'b0;
        chk("t5_clr_hi",  int'(bus.clr_o),  1);
        chk("t5_inc_hi",  int'(bus.inc_o),  1);
        chk("t5_pend0",   int'(bus.pend_o), 0);
        base_i = inc_falls;
        tick();
        chk("t5_clr_lo",  int'(bus.clr_o),  0);
        chk("t5_gap1",    int'(bus.busy_o), 1);
        tick();
        chk("t5_gap2",    int'(bus.busy_o), 1);
        tick();
        chk("t5_idle",    int'(bus.busy_o), 0);
        repeat (10) tick();
        chk("t5_no_pulse", inc_falls - base_i, 0);

        // 6: async reset mid LOW_DN with three queued downs
        bus.dn_req_i = 1'b1; repeat (5) tick(); bus.dn_req_i = 1'b0;
        tick(); tick();
        chk("t6_dec_low", int'(bus.dec_o),  0);
        chk("t6_pend",    int'(bus.pend_o), -3);
        #2 rst = 1'b1;
        #1;
        chk("t6_rst_dec",  int'(bus.dec_o),  1);
        chk("t6_rst_pend", int'(bus.pend_o), 0);
        tick();
        rst = 1'b0;
        base_d = dec_falls;
        repeat (20) tick();
        chk("t6_no_pulse", dec_falls - base_d, 0);
        chk("t6_busy",     int'(bus.busy_o), 0);

        chk("never_both_low", both_low, 0);

        $display("[TB] %0d tests run, %0d failed", tests_run, fails);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end
endmodule
`default_nettype wire
